encode_n_rr: RTL
================

# encode_n_rr

Parametrised, registered N-to-log2(N) request encoder and the successor to the fixed 4-to-2 encoder. It accepts an N-bit request vector and selects one active bit by fixed or round-robin priority. The result is presented as an index plus a one-hot grant with a valid/ready handshake. It sits between request sources (buttons, channel flags, FIFO non-empty lines) and any consumer that services one channel at a time.

## Interface
Parameters:
- N, 8, number of request lines; legal range 2..64; non-power-of-2 allowed.
- W, derived, index width = $clog2(N); not overridable.
- MODE, 1, selection mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  request vector, sampled on clk.
- out_ready  in  1  consumer accepts the current result.
- out_valid  out  1  result register holds a valid selection.
- out_idx  out  W  index of selected request.
- out_grant  out  N  one-hot of selected request (bit out_idx set).
- out_multi  out  1  more than one req bit was set when the result was captured.
- busy_cnt  out  8  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Load condition: `load = (!out_valid || out_ready) && (req != 0)`.
- When load is true:
  - Capture the selection into out_idx and out_grant.
  - Set out_valid to 1.
  - Set out_multi = (popcount(req) > 1).
- If `(!out_valid || out_ready) && req == 0`:
  - out_valid goes to 0.
  - out_idx, out_grant and out_multi hold their last values.
- While out_valid=1 and out_ready=0:
  - All outputs hold, regardless of req changes.
  - busy_cnt increments, saturating at 255.
  - busy_cnt clears to 0 on any accept cycle.
- Fixed mode: select the lowest-index set bit.
- Round-robin mode:
  - Search starts at `ptr+1` and wraps from N-1 to 0; select the first set bit found.
  - On load, ptr is updated to the selected index.
  - ptr is not updated while out_valid holds.
- Wrap for non-power-of-2 N: after index N-1 the search continues at 0. Indices >= N are never produced.
- Reset values (asynchronous):
  - out_valid=0, out_idx=0, out_grant=0, out_multi=0, busy_cnt=0.
  - ptr=N-1, so the first round-robin search starts at index 0.
- Reset mid-handshake: a pending result is discarded and no accept is reported.
- No X on outputs after reset, including when req contains X; the bench holds req at known values.

## Timing
- Latency: req sampled at edge k appears on outputs after edge k (one cycle).
- Throughput: one result per cycle when out_ready is held at 1 and req is non-zero.
- Accept and reload in the same cycle (out_valid=1, out_ready=1, req!=0):
  - The new result replaces the old one at the same edge.
  - There is no bubble.
- out_ready is ignored when out_valid=0.
- Outputs are registered only; there is no combinational path from req or out_ready to any output.

## Structure
- Shared package enc_pkg:
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - Popcount-greater-than-one function.
- One sub-module prio_pick holds the combinational search:
  - Inputs: req[N], start[W].
  - Outputs: idx[W], grant[N], any.
  - Fixed mode instantiates it with start tied to 0.
- The top level holds the result registers, ptr, busy_cnt and the handshake logic.

## Test plan
- Reset, then N=8, MODE=0, req=8'b0010_0100, out_ready=1 -> next cycle out_valid=1, out_idx=2, out_grant=8'h04, out_multi=1.
- MODE=1, N=8, req=8'hFF held, out_ready=1 -> out_idx sequence 0,1,2,…,7,0 on consecutive cycles; out_multi=1 throughout.
- MODE=1, N=5, req=5'b10001 held, out_ready=1 -> out_idx alternates 0,4,0,4; no index >= 5 is ever produced.
- Stall: result idx=3 pending, out_ready=0 for 300 cycles while req changes -> outputs frozen, busy_cnt saturates at 255. Raising out_ready clears busy_cnt and loads the new req the same edge.
- req=0 with out_ready=1 after a result -> out_valid=0 next cycle, out_idx holds.
- Assert rst_n low asynchronously mid-stall -> all outputs immediately at reset values. After release with req=8'h80, MODE=1, the first out_idx is 7.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants and helpers for the request encoder family.
package enc_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // True when more than one bit of v is set (clearing the lowest set bit leaves something).
   function automatic logic multi_hot(input logic [63:0] v);
      return (v & (v - 64'd1)) != 64'd0;
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational circular priority search: first set bit of req at or after start, wrapping at N-1.
module prio_pick #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic [N-1:0] grant,
   output logic         any
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W:0]     off;
   logic [W:0]     sum;

   // Rotate req so start sits at bit 0, find the lowest set bit, then map the offset back modulo N.
   always_comb begin
      dbl   = {req, req};
      rot   = dbl[start +: N];
      any   = 1'b0;
      off   = '0;
      for (int unsigned i = N; i > 0; i--) begin
         if (rot[i-1]) begin
            any = 1'b1;
            off = (W+1)'(i-1);
         end
      end
      sum = {1'b0, start} + off;
      if (sum >= (W+1)'(N)) begin
         sum = sum - (W+1)'(N);
      end
      idx   = sum[W-1:0];
      grant = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/encode_n_rr.sv
// Registered N-to-log2(N) request encoder with fixed or round-robin priority and valid/ready output.
module encode_n_rr
   import enc_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int MODE = 1,
   localparam int W    = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_grant,
   output logic         out_multi,
   output logic [7:0]   busy_cnt
);

   logic [W-1:0] start;
   logic [W-1:0] sel_idx;
   logic [N-1:0] sel_grant;
   logic         sel_any;
   logic         take;
   logic         load;

   // Result slot is free when empty or being accepted this cycle.
   assign take = !out_valid || out_ready;
   assign load = take && sel_any;

   generate
      if (MODE == MODE_RR) begin : g_rr
         logic [W-1:0] ptr;

         assign start = (ptr == W'(N-1)) ? '0 : ptr + 1'b1;

         // Remember the last granted index; reset to N-1 so the first search begins at 0.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ptr <= W'(N-1);
            end else if (load) begin
               ptr <= sel_idx;
            end
         end
      end else begin : g_fixed
         assign start = '0;
      end
   endgenerate

   prio_pick #(.N(N)) u_pick (
      .req   (req),
      .start (start),
      .idx   (sel_idx),
      .grant (sel_grant),
      .any   (sel_any)
   );

   // Result registers: load a new selection when the slot frees, drop valid when nothing is requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_grant <= '0;
         out_multi <= 1'b0;
      end else if (take) begin
         if (sel_any) begin
            out_valid <= 1'b1;
            out_idx   <= sel_idx;
            out_grant <= sel_grant;
            out_multi <= multi_hot(64'(req));
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // Saturating stall counter; any cycle that is not a stall clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= '0;
      end else if (out_valid && !out_ready) begin
         if (busy_cnt != 8'hFF) begin
            busy_cnt <= busy_cnt + 8'd1;
         end
      end else begin
         busy_cnt <= '0;
      end
   end

endmodule
